// File: rtl/sram_seq_pkg.sv
// Shared types for the byte-serial SRAM sequencer: command opcodes and FSM states.
package sram_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD_ADDR = 2'd0,
    OP_LOAD_DATA = 2'd1,
    OP_WRITE     = 2'd2,
    OP_READ      = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STREAM = 2'd3
  } state_e;

endpackage

// File: rtl/sram_seq_serializer.sv
// Captures one SRAM word into rd_reg and streams it out MSB byte first, one byte per cycle.
module sram_seq_serializer
  import sram_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              stream_en,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              rd_valid,
  output logic [7:0]        rd_byte,
  output logic              last
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_W-1:0] rd_reg;
  logic [CNT_W-1:0]  byte_cnt;

  // rd_reg shifts left as bytes leave, so the current byte is always the top one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_reg   <= '0;
      byte_cnt <= '0;
    end else if (capture) begin
      rd_reg   <= sram_dout;
      byte_cnt <= '0;
    end else if (stream_en) begin
      rd_reg   <= rd_reg << BYTE_W;
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  assign last     = (byte_cnt == CNT_W'(NBYTES - 1));
  assign rd_valid = stream_en;
  assign rd_byte  = stream_en ? rd_reg[DATA_W-1 -: BYTE_W] : '0;

endmodule

// File: rtl/sram_seq_ctrl.sv
// Byte-command sequencer for a synchronous SRAM: load address/data bytes, write, read-and-stream.
// Optional feature: define SRAM_SEQ_AUTOINC_EN to post-increment the address after every access.
module sram_seq_ctrl
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DOUT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_byte,
  output logic              rd_valid,
  output logic [7:0]        rd_byte,
  output logic              busy,
  output logic              sram_csb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic [1:0]        dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and anything offered while it is low is dropped.

  localparam logic [1:0] WAIT_LAST = 2'(DOUT_LAT - 1);

  state_e            state_q, state_d;
  cmd_op_e           op;
  logic              cmd_fire;
  logic              is_read_q;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              capture;
  logic              stream_last;

  assign op       = cmd_op_e'(cmd_op);
  assign cmd_fire = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE:   if (cmd_fire && (op == OP_WRITE || op == OP_READ)) state_d = ST_ACCESS;
      ST_ACCESS: state_d = is_read_q ? ST_WAIT : ST_IDLE;
      // WAIT covers DOUT_LAT-1 pure latency cycles plus the cycle whose closing edge samples dout.
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          capture = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: if (stream_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      is_read_q <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) is_read_q <= (op == OP_READ);
      if (state_q == ST_ACCESS) wait_cnt <= '0;
      else if (state_q == ST_WAIT) wait_cnt <= wait_cnt + 2'd1;
    end
  end

  // Address and data registers only move on LOAD commands (plus optional post-increment).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      if (cmd_fire && op == OP_LOAD_ADDR) addr_reg <= ADDR_W'({addr_reg, cmd_byte});
`ifdef SRAM_SEQ_AUTOINC_EN
      else if (state_q == ST_ACCESS) addr_reg <= addr_reg + ADDR_W'(1);
`endif
      if (cmd_fire && op == OP_LOAD_DATA) data_reg <= DATA_W'({data_reg, cmd_byte});
    end
  end

  sram_seq_serializer #(.DATA_W(DATA_W)) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .stream_en (state_q == ST_STREAM),
    .sram_dout (sram_dout),
    .rd_valid  (rd_valid),
    .rd_byte   (rd_byte),
    .last      (stream_last)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign sram_csb  = (state_q != ST_ACCESS);
  assign sram_web  = !((state_q == ST_ACCESS) && !is_read_q);
  assign sram_addr = addr_reg;
  assign sram_din  = data_reg;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Scoreboard bench for sram_seq_ctrl: random and directed commands against a queue-based reference model.
module tb_sram_seq_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_byte;
  logic              rd_valid, busy, sram_csb, sram_web;
  logic [7:0]        rd_byte;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din, sram_dout;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  sram_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DOUT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_byte(cmd_byte), .rd_valid(rd_valid), .rd_byte(rd_byte),
    .busy(busy), .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout), .dbg_state(dbg_state)
  );

  // SRAM model: data appears LAT cycles after the access cycle, garbage otherwise.
  logic [DATA_W-1:0] mem   [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] dpipe [0:LAT-1];
  always @(posedge clk) begin
    if (!sram_csb && !sram_web) mem[sram_addr] <= sram_din;
    if (!sram_csb && sram_web) dpipe[0] <= mem[sram_addr];
    else dpipe[0] <= 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign sram_dout = dpipe[LAT-1];

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } acc_t;

  acc_t       exp_acc_q[$];
  logic [7:0] exp_rd_q[$];
  int checks = 0;
  int failures = 0;
  int acc_seen = 0;

  // Reference model state
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  bit                ref_written [0:(1<<ADDR_W)-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops the expected queues whenever the DUT strobes the SRAM or emits a byte.
  always @(negedge clk) begin : monitor
    acc_t e;
    if (rst_n) begin
      if (!sram_csb) begin
        acc_seen++;
        if (exp_acc_q.size() == 0) fail_now("unexpected_sram_access");
        else begin
          e = exp_acc_q.pop_front();
          check("acc_we", !sram_web, e.we);
          check("acc_addr", sram_addr, e.addr);
          if (e.we) check("acc_din", sram_din, e.din);
        end
      end
      if (rd_valid) begin
        check("busy_in_stream", busy, 1'b1);
        if (exp_rd_q.size() == 0) fail_now("unexpected_rd_valid");
        else check("rd_byte", rd_byte, exp_rd_q.pop_front());
      end
    end
  end

  task automatic post_access();
`ifdef SRAM_SEQ_AUTOINC_EN
    m_addr = m_addr + 1'b1;
`endif
  endtask

  task automatic model_issue(input logic [1:0] op, input logic [7:0] b);
    logic [DATA_W-1:0] w;
    case (op)
      2'd0: m_addr = (m_addr << 8) | ADDR_W'(b);
      2'd1: m_data = (m_data << 8) | DATA_W'(b);
      2'd2: begin
        exp_acc_q.push_back('{we: 1'b1, addr: m_addr, din: m_data});
        ref_mem[m_addr] = m_data;
        ref_written[m_addr] = 1'b1;
        post_access();
      end
      default: begin
        exp_acc_q.push_back('{we: 1'b0, addr: m_addr, din: '0});
        w = ref_mem[m_addr];
        for (int i = 0; i < NB; i++) exp_rd_q.push_back(w[DATA_W-1-8*i -: 8]);
        post_access();
      end
    endcase
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_byte = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      fail_now("cmd_ready_timeout");
      cmd_valid = 1'b0;
      return;
    end
    model_issue(op, b);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) fail_now("idle_timeout");
  endtask

  task automatic load_word(input logic [DATA_W-1:0] w);
    for (int i = 0; i < NB; i++) send_cmd(2'd1, w[DATA_W-1-8*i -: 8]);
  endtask

  initial begin
    int a0;
    logic [1:0] op;
    cmd_valid = 1'b0; cmd_op = '0; cmd_byte = '0;
    m_addr = '0; m_data = '0;
    for (int i = 0; i < (1<<ADDR_W); i++) begin ref_mem[i] = '0; ref_written[i] = 1'b0; end

    // Reset values, during and after reset
    repeat (3) @(negedge clk);
    check("rst_csb", sram_csb, 1'b1);
    check("rst_web", sram_web, 1'b1);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_byte", rd_byte, 8'h00);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_csb", sram_csb, 1'b1);
    check("rel_web", sram_web, 1'b1);
    check("rel_rd_valid", rd_valid, 1'b0);
    check("rel_cmd_ready", cmd_ready, 1'b1);
    check("rel_addr", sram_addr, '0);
    check("rel_din", sram_din, '0);

    // Directed write then read of DEADBEEF at 0x12
    send_cmd(2'd0, 8'h12);
    load_word(32'hDEAD_BEEF);
    check("din_loaded", sram_din, 32'hDEAD_BEEF);
    send_cmd(2'd2, 8'h00);
    wait_idle();
    send_cmd(2'd0, 8'h12);
    send_cmd(2'd3, 8'h00);
    wait_idle();
    check("data_reg_kept", sram_din, 32'hDEAD_BEEF);

    // READ held during the whole transaction must be ignored
    send_cmd(2'd0, 8'h12);
    a0 = acc_seen;
    send_cmd(2'd3, 8'h00);
    cmd_valid = 1'b1; cmd_op = 2'd3;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    cmd_valid = 1'b0;
    check("held_read_ready", cmd_ready, 1'b1);
    check("held_read_one_access", acc_seen - a0, 1);

    // Address boundary: two writes starting at 0xFF
    send_cmd(2'd0, 8'hFF);
    load_word(DATA_W'($urandom));
    send_cmd(2'd2, 8'h00);
    send_cmd(2'd2, 8'h00);
    wait_idle();
    check("addr_after_two_writes", sram_addr, m_addr);

    // Random command mix; reads only target addresses the model knows
    for (int k = 0; k < 120; k++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3 && !ref_written[m_addr]) op = 2'd2;
      send_cmd(op, 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_idle();
    check("rand_addr_reg", sram_addr, m_addr);
    check("rand_data_reg", sram_din, m_data);

    // Reset in WAIT aborts the read
    send_cmd(2'd0, 8'h12);
    send_cmd(2'd3, 8'h00);
    for (int n = 0; n < 20 && dbg_state != 2'd2; n++) @(negedge clk);
    check("reached_wait", dbg_state, 2'd2);
    rst_n = 1'b0;
    m_addr = '0; m_data = '0;
    exp_rd_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("wait_rst_csb", sram_csb, 1'b1);
      check("wait_rst_rd_valid", rd_valid, 1'b0);
      check("wait_rst_busy", busy, 1'b0);
    end
    rst_n = 1'b1;
    for (int n = 0; n < LAT + NB + 2; n++) begin
      @(negedge clk);
      check("post_rst_csb", sram_csb, 1'b1);
      check("post_rst_rd_valid", rd_valid, 1'b0);
      check("post_rst_ready", cmd_ready, 1'b1);
    end
    check("post_rst_addr", sram_addr, '0);

    // Recovery after the aborted read
    load_word(32'h0123_4567);
    send_cmd(2'd2, 8'h00);
    send_cmd(2'd0, 8'h00);
    send_cmd(2'd3, 8'h00);
    wait_idle();
    repeat (4) @(negedge clk);
    check("acc_q_empty", exp_acc_q.size(), 0);
    check("rd_q_empty", exp_rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
